hspan_zfill_ctrl: RTL and testbench
===================================

Name: hspan_zfill_ctrl

Overview:
Parametrised horizontal-span z-buffered fill controller. It is the next generation of the hline z-buffer pcore FSM.
- Splits a span of dx pixels into bursts of up to BURST_LEN words.
- Per burst: reads the z-buffer and framebuffer into the pcore input FIFOs, interpolates z with a Bresenham error term, and depth-tests each pixel with a selectable compare function.
- Writes both buffers back with per-pixel byte enables.
- New over the previous generation: exact partial final burst, selectable depth function, optional z-write suppression.

Parameters:
BURST_LEN, 256, max words per burst (power of 2, ≤ 2^CNT_W-1)
CNT_W, 16, width of pixel/beat counters
Z_W, 32, depth value width
ADDR_W, 32, byte address width
PIX_BYTES, 4, bytes per pixel/word (address stride)

Ports:
clk  in  1  clock
nreset  in  1  synchronous active-low reset
start  in  1  begin span (sampled in IDLE/DONE)
fb_addr  in  ADDR_W  framebuffer span start byte address
zb_addr  in  ADDR_W  z-buffer span start byte address
dx  in  CNT_W  span length in pixels (unsigned)
z1  in  Z_W  depth at first pixel
slope  in  Z_W  signed integer z step per pixel
rem  in  CNT_W  Bresenham error increment
err  in  CNT_W  initial error
rgbx  in  32  fill colour
zfunc  in  2  0 LESS, 1 LEQUAL, 2 GREATER, 3 ALWAYS
zwrite_en  in  1  1 = write z-buffer back
mem_beat  in  1  one word accepted/returned by bus this cycle
rd_req  out  1  burst read request
wr_req  out  1  burst write request
mem_addr  out  ADDR_W  burst byte address
mem_len  out  CNT_W  words in current burst
z_fifo_push  out  1  route bus read data into z input FIFO
f_fifo_push  out  1  route bus read data into f input FIFO
in_pop  out  1  pop both input FIFOs
out_push  out  1  push z_out/f_out/pass into output FIFOs
z_out_pop  out  1  z output FIFO feeds bus write data
f_out_pop  out  1  f output FIFO feeds bus write data
z_fifo_in  in  Z_W  existing depth (head of z input FIFO)
f_fifo_in  in  32  existing colour (head of f input FIFO)
z_out  out  Z_W  depth to write
f_out  out  32  colour to write
pass  out  1  depth test passed (byte-enable source)
busy  out  1  not IDLE/DONE
done  out  1  high in DONE
state_dbg  out  4  current state

Behaviour:
- Reset: state IDLE; all outputs 0; all internal registers 0.
- States: IDLE, SETUP, LD_Z, LD_F, INTERP, WR_Z, WR_F, DONE.
- IDLE/DONE + start → SETUP. SETUP latches remaining=dx, z=z1, error=err, offset=0.
- LOOP test, performed in SETUP and after WR_F:
  - remaining==0 → DONE.
  - Otherwise len=min(remaining,BURST_LEN), beat=0, → LD_Z.
  - If zfunc==ALWAYS, go to LD_F instead (LD_Z skipped).
- LD_Z/LD_F:
  - rd_req=1 until beat==len, then deasserted in the same cycle the final mem_beat is counted (combinational gate).
  - mem_addr = zb_addr/fb_addr + offset. mem_len=len.
  - z_fifo_push/f_fifo_push equals the state decode.
  - On the last beat: LD_Z → LD_F; LD_F → INTERP, beat cleared.
- INTERP: exactly len cycles, one pixel per cycle; in_pop=out_push=1 each cycle.
  - pass = compare(z, z_fifo_in) per zfunc, unsigned compare; ALWAYS → 1.
  - z_out = (pass & zwrite_en) ? z : z_fifo_in.
  - f_out = pass ? rgbx : f_fifo_in.
  - Interpolation, all in the same cycle: e' = error + rem.
    - If e' ≥ dx: z += slope + sign(slope) (+1 for slope ≥ 0, else -1) and error = e' − dx.
    - Otherwise: z += slope and error = e'.
  - Arithmetic is modulo 2^Z_W with no saturation.
- WR_Z → WR_F. wr_req asserts as in the LD states; z_out_pop/f_out_pop asserts in the respective state.
  - If zwrite_en=0, WR_Z is skipped; its output FIFO is still drained internally by pulsing z_out_pop for len cycles with wr_req=0.
- WR_F last beat: remaining −= len; offset += len·PIX_BYTES; re-run the LOOP test.
- mem_beat outside LD/WR states is ignored. beat never exceeds len.
- start while busy is ignored. Inputs must stay stable while busy; zfunc, zwrite_en and dx are sampled only in SETUP.
- Reset mid-burst returns to IDLE next cycle and all requests drop. FIFOs are flushed externally.

Decomposition:
- Package hspan_pkg: state encoding, ZFUNC_* constants, sign-step helper function.
- One sub-module: hspan_zinterp. Holds the z/error registers with load/step controls, the compare logic, and produces pass/z_out/f_out.

Test Plan:
- dx=4, z1=100, slope=10, rem=0, err=0, zfunc=LESS, z_fifo_in=1000 → one burst, mem_len=4, z_out 100,110,120,130, pass=1111, done.
- dx=300, BURST_LEN=256 → bursts len 256 then 44. Second burst mem_addr = base+1024 for both buffers; 4 read + 4 write bursts total.
- dx=3, z1=50, slope=0, existing z 40,50,60 → LESS gives pass 0,0,1; LEQUAL gives 0,1,1; GREATER gives 1,0,0.
- dx=3, slope=-2, rem=1, err=0, dx threshold 3 → z 20,18,16, then error=3 triggers step −3; verify error wraps to 0.
- zwrite_en=0, all pass → no z-buffer wr_req; f writes rgbx; z_out_pop pulses len times. dx=0 → SETUP→DONE, no requests.
- Reset asserted mid LD_F, then start → fresh span from offset 0; rd_req low the cycle after reset.

Source files
------------

// File: rtl/hspan_pkg.sv
// Shared definitions for the horizontal-span z-buffered fill controller.
// Contents: controller state encoding, depth-compare function codes and the
// sign-step helper used by the Bresenham z interpolator.
package hspan_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SETUP  = 4'd1,
        ST_LD_Z   = 4'd2,
        ST_LD_F   = 4'd3,
        ST_INTERP = 4'd4,
        ST_WR_Z   = 4'd5,
        ST_WR_F   = 4'd6,
        ST_DONE   = 4'd7
    } state_t;

    localparam logic [1:0] ZFUNC_LESS    = 2'd0;
    localparam logic [1:0] ZFUNC_LEQUAL  = 2'd1;
    localparam logic [1:0] ZFUNC_GREATER = 2'd2;
    localparam logic [1:0] ZFUNC_ALWAYS  = 2'd3;

    // Extra unit step applied on an error overflow: +1 for a non-negative
    // slope, -1 for a negative one. Returned as a 2-bit two's complement
    // value; the caller sign-extends it to the depth width.
    function automatic logic [1:0] sign_step(input logic neg);
        if (neg) begin
            sign_step = 2'b11;
        end else begin
            sign_step = 2'b01;
        end
    endfunction

endpackage

// File: rtl/hspan_zfill_ctrl_if.sv
// Memory-bus and pcore FIFO handshake bundle of the span fill controller.
// master: controller side (burst requests, FIFO push/pop strobes, pixel data
//         out; bus beat strobe and FIFO heads in).
// slave : bus / FIFO side (the reverse directions).
interface hspan_zfill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    parameter int Z_W    = 32
) ();
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [CNT_W-1:0]  mem_len;
    logic              mem_beat;
    logic              z_fifo_push;
    logic              f_fifo_push;
    logic              in_pop;
    logic              out_push;
    logic              z_out_pop;
    logic              f_out_pop;
    logic [Z_W-1:0]    z_fifo_in;
    logic [31:0]       f_fifo_in;
    logic [Z_W-1:0]    z_out;
    logic [31:0]       f_out;
    logic              pass;

    modport master (
        output rd_req, wr_req, mem_addr, mem_len,
        output z_fifo_push, f_fifo_push, in_pop, out_push, z_out_pop, f_out_pop,
        output z_out, f_out, pass,
        input  mem_beat, z_fifo_in, f_fifo_in
    );

    modport slave (
        input  rd_req, wr_req, mem_addr, mem_len,
        input  z_fifo_push, f_fifo_push, in_pop, out_push, z_out_pop, f_out_pop,
        input  z_out, f_out, pass,
        output mem_beat, z_fifo_in, f_fifo_in
    );
endinterface

// File: rtl/hspan_zinterp.sv
// Bresenham z interpolator and depth tester for one span.
// Ports: clk/nreset; load (latch z1/err), step (advance one pixel),
// active (pixel outputs valid); span config z1, slope, err, rem, dx, zfunc,
// zwrite_en, rgbx; FIFO heads z_fifo_in/f_fifo_in; results pass, z_out, f_out
// (all zero while not active).
module hspan_zinterp
    import hspan_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int Z_W   = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic             step,
    input  logic             active,
    input  logic [Z_W-1:0]   z1,
    input  logic [Z_W-1:0]   slope,
    input  logic [CNT_W-1:0] err,
    input  logic [CNT_W-1:0] rem,
    input  logic [CNT_W-1:0] dx,
    input  logic [1:0]       zfunc,
    input  logic             zwrite_en,
    input  logic [31:0]      rgbx,
    input  logic [Z_W-1:0]   z_fifo_in,
    input  logic [31:0]      f_fifo_in,
    output logic             pass,
    output logic [Z_W-1:0]   z_out,
    output logic [31:0]      f_out
);

    logic [Z_W-1:0]   z_r;
    logic [CNT_W-1:0] error_r;
    logic [CNT_W:0]   e_sum_s;
    logic [CNT_W:0]   e_sub_s;
    logic             carry_s;
    logic [1:0]       ss_s;
    logic [Z_W-1:0]   z_next_s;
    logic             cmp_s;

    // Next error/z: one extra signed unit step whenever the error term reaches dx.
    always_comb begin
        e_sum_s = {1'b0, error_r} + {1'b0, rem};
        e_sub_s = e_sum_s - {1'b0, dx};
        carry_s = (e_sum_s >= {1'b0, dx});
        ss_s    = sign_step(slope[Z_W-1]);
        if (carry_s) begin
            z_next_s = z_r + slope + {{(Z_W-2){ss_s[1]}}, ss_s};
        end else begin
            z_next_s = z_r + slope;
        end
    end

    // z / error registers: loaded at span setup, advanced once per pixel.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            z_r     <= {Z_W{1'b0}};
            error_r <= {CNT_W{1'b0}};
        end else if (load) begin
            z_r     <= z1;
            error_r <= err;
        end else if (step) begin
            z_r     <= z_next_s;
            error_r <= carry_s ? e_sub_s[CNT_W-1:0] : e_sum_s[CNT_W-1:0];
        end else begin
            z_r     <= z_r;
            error_r <= error_r;
        end
    end

    // Unsigned depth compare of the interpolated z against the stored depth.
    always_comb begin
        case (zfunc)
            ZFUNC_LESS:    cmp_s = (z_r <  z_fifo_in);
            ZFUNC_LEQUAL:  cmp_s = (z_r <= z_fifo_in);
            ZFUNC_GREATER: cmp_s = (z_r >  z_fifo_in);
            ZFUNC_ALWAYS:  cmp_s = 1'b1;
            default:       cmp_s = 1'b1;
        endcase
    end

    // Pixel results; held at zero outside the interpolation phase.
    always_comb begin
        if (active) begin
            pass  = cmp_s;
            z_out = (cmp_s && zwrite_en) ? z_r : z_fifo_in;
            f_out = cmp_s ? rgbx : f_fifo_in;
        end else begin
            pass  = 1'b0;
            z_out = {Z_W{1'b0}};
            f_out = 32'd0;
        end
    end

endmodule

// File: rtl/hspan_zfill_ctrl.sv
// Horizontal-span z-buffered fill controller.
// Splits a span of dx pixels into bursts of at most BURST_LEN words; per burst
// it loads z and colour into the pcore input FIFOs, depth-tests and
// interpolates one pixel per cycle, then writes both buffers back.
// Ports: clk, nreset (sync, active low), start, span config (fb_addr, zb_addr,
// dx, z1, slope, rem, err, rgbx, zfunc, zwrite_en), bus (memory/FIFO
// handshake interface, master side), status busy/done/state_dbg.
module hspan_zfill_ctrl
    import hspan_pkg::*;
#(
    parameter int BURST_LEN = 256,
    parameter int CNT_W     = 16,
    parameter int Z_W       = 32,
    parameter int ADDR_W    = 32,
    parameter int PIX_BYTES = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [ADDR_W-1:0] fb_addr,
    input  logic [ADDR_W-1:0] zb_addr,
    input  logic [CNT_W-1:0]  dx,
    input  logic [Z_W-1:0]    z1,
    input  logic [Z_W-1:0]    slope,
    input  logic [CNT_W-1:0]  rem,
    input  logic [CNT_W-1:0]  err,
    input  logic [31:0]       rgbx,
    input  logic [1:0]        zfunc,
    input  logic              zwrite_en,
    hspan_zfill_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [3:0]        state_dbg
);

    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(PIX_BYTES);

    state_t            state_r, next_state_s, lp_next_s;
    logic [CNT_W-1:0]  remaining_r, len_r, beat_r, dx_r;
    logic [ADDR_W-1:0] offset_r;
    logic [1:0]        zfunc_r;
    logic              zwrite_en_r;

    logic [CNT_W-1:0]  lp_rem_s, lp_len_s;
    logic              lp_always_s;
    logic              beat_inc_s, last_s;
    logic              rd_req_s, wr_req_s, zpush_s, fpush_s, in_pop_s, out_push_s;
    logic              zpop_s, fpop_s;
    logic [ADDR_W-1:0] addr_s;
    logic [CNT_W-1:0]  mlen_s;
    logic              pass_s;
    logic [Z_W-1:0]    z_out_s;
    logic [31:0]       f_out_s;

    // Loop test: pixels still to do and the next burst length. In SETUP it
    // works on the live inputs because the span registers load that same edge.
    always_comb begin
        if (state_r == ST_SETUP) begin
            lp_rem_s    = dx;
            lp_always_s = (zfunc == ZFUNC_ALWAYS);
        end else begin
            lp_rem_s    = remaining_r - len_r;
            lp_always_s = (zfunc_r == ZFUNC_ALWAYS);
        end
        if (lp_rem_s > BURST_MAX) begin
            lp_len_s = BURST_MAX;
        end else begin
            lp_len_s = lp_rem_s;
        end
        if (lp_rem_s == {CNT_W{1'b0}}) begin
            lp_next_s = ST_DONE;
        end else if (lp_always_s) begin
            lp_next_s = ST_LD_F;
        end else begin
            lp_next_s = ST_LD_Z;
        end
    end

    // Beat advance: bus beats in transfer states, one per cycle while
    // interpolating or while draining the z output FIFO without a write.
    always_comb begin
        case (state_r)
            ST_LD_Z, ST_LD_F, ST_WR_F: beat_inc_s = bus.mem_beat;
            ST_INTERP:                 beat_inc_s = 1'b1;
            ST_WR_Z:                   beat_inc_s = zwrite_en_r ? bus.mem_beat : 1'b1;
            default:                   beat_inc_s = 1'b0;
        endcase
    end

    assign last_s = beat_inc_s && (beat_r == (len_r - ONE));

    // Next state and per-state strobes.
    always_comb begin
        next_state_s = state_r;
        rd_req_s     = 1'b0;
        wr_req_s     = 1'b0;
        zpush_s      = 1'b0;
        fpush_s      = 1'b0;
        in_pop_s     = 1'b0;
        out_push_s   = 1'b0;
        zpop_s       = 1'b0;
        fpop_s       = 1'b0;
        addr_s       = {ADDR_W{1'b0}};
        mlen_s       = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_SETUP: begin
                next_state_s = lp_next_s;
            end
            ST_LD_Z: begin
                rd_req_s     = (beat_r != len_r);
                zpush_s      = 1'b1;
                addr_s       = zb_addr + offset_r;
                mlen_s       = len_r;
                next_state_s = last_s ? ST_LD_F : ST_LD_Z;
            end
            ST_LD_F: begin
                rd_req_s     = (beat_r != len_r);
                fpush_s      = 1'b1;
                addr_s       = fb_addr + offset_r;
                mlen_s       = len_r;
                next_state_s = last_s ? ST_INTERP : ST_LD_F;
            end
            ST_INTERP: begin
                in_pop_s     = 1'b1;
                out_push_s   = 1'b1;
                next_state_s = last_s ? ST_WR_Z : ST_INTERP;
            end
            ST_WR_Z: begin
                // With z writes suppressed this state only drains the z output FIFO.
                zpop_s = 1'b1;
                if (zwrite_en_r) begin
                    wr_req_s = (beat_r != len_r);
                    addr_s   = zb_addr + offset_r;
                    mlen_s   = len_r;
                end else begin
                    wr_req_s = 1'b0;
                end
                next_state_s = last_s ? ST_WR_F : ST_WR_Z;
            end
            ST_WR_F: begin
                wr_req_s     = (beat_r != len_r);
                fpop_s       = 1'b1;
                addr_s       = fb_addr + offset_r;
                mlen_s       = len_r;
                next_state_s = last_s ? lp_next_s : ST_WR_F;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, span bookkeeping and beat counter.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            remaining_r <= {CNT_W{1'b0}};
            len_r       <= {CNT_W{1'b0}};
            beat_r      <= {CNT_W{1'b0}};
            dx_r        <= {CNT_W{1'b0}};
            offset_r    <= {ADDR_W{1'b0}};
            zfunc_r     <= 2'd0;
            zwrite_en_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_SETUP) begin
                remaining_r <= dx;
                dx_r        <= dx;
                zfunc_r     <= zfunc;
                zwrite_en_r <= zwrite_en;
                offset_r    <= {ADDR_W{1'b0}};
                len_r       <= lp_len_s;
            end else if ((state_r == ST_WR_F) && last_s) begin
                remaining_r <= lp_rem_s;
                offset_r    <= offset_r + (ADDR_W'(len_r) * STRIDE);
                len_r       <= lp_len_s;
            end else begin
                remaining_r <= remaining_r;
                offset_r    <= offset_r;
                len_r       <= len_r;
            end
            if ((state_r == ST_SETUP) || last_s) begin
                beat_r <= {CNT_W{1'b0}};
            end else if (beat_inc_s) begin
                beat_r <= beat_r + ONE;
            end else begin
                beat_r <= beat_r;
            end
        end
    end

    hspan_zinterp #(
        .CNT_W (CNT_W),
        .Z_W   (Z_W)
    ) u_zinterp (
        .clk       (clk),
        .nreset    (nreset),
        .load      (state_r == ST_SETUP),
        .step      (state_r == ST_INTERP),
        .active    (state_r == ST_INTERP),
        .z1        (z1),
        .slope     (slope),
        .err       (err),
        .rem       (rem),
        .dx        (dx_r),
        .zfunc     (zfunc_r),
        .zwrite_en (zwrite_en_r),
        .rgbx      (rgbx),
        .z_fifo_in (bus.z_fifo_in),
        .f_fifo_in (bus.f_fifo_in),
        .pass      (pass_s),
        .z_out     (z_out_s),
        .f_out     (f_out_s)
    );

    assign bus.rd_req      = rd_req_s;
    assign bus.wr_req      = wr_req_s;
    assign bus.mem_addr    = addr_s;
    assign bus.mem_len     = mlen_s;
    assign bus.z_fifo_push = zpush_s;
    assign bus.f_fifo_push = fpush_s;
    assign bus.in_pop      = in_pop_s;
    assign bus.out_push    = out_push_s;
    assign bus.z_out_pop   = zpop_s;
    assign bus.f_out_pop   = fpop_s;
    assign bus.pass        = pass_s;
    assign bus.z_out       = z_out_s;
    assign bus.f_out       = f_out_s;
    assign busy            = (state_r != ST_IDLE) && (state_r != ST_DONE);
    assign done            = (state_r == ST_DONE);
    assign state_dbg       = state_r;

endmodule

// File: tb/tb_hspan_zfill_ctrl.sv
// Self-checking bench for hspan_zfill_ctrl: directed spans plus random spans,
// each compared against a span-level reference model (burst list + pixels).
module tb_hspan_zfill_ctrl;

    localparam int CNT_W = 16;
    localparam int Z_W   = 32;
    localparam int ADDR_W = 32;
    localparam int BL    = 256;
    localparam int PB    = 4;
    localparam int K_RZ = 0, K_RF = 1, K_WZ = 2, K_WF = 3;
    localparam int SPAN_LIMIT = 9000;

    logic        clk = 1'b0;
    logic        nreset, start;
    logic [31:0] fb_addr, zb_addr, z1, slope, rgbx;
    logic [15:0] dx, rem, err;
    logic [1:0]  zfunc;
    logic        zwrite_en, busy, done;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    hspan_zfill_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .Z_W(Z_W)) bus ();

    hspan_zfill_ctrl #(
        .BURST_LEN(BL), .CNT_W(CNT_W), .Z_W(Z_W), .ADDR_W(ADDR_W), .PIX_BYTES(PB)
    ) dut (
        .clk(clk), .nreset(nreset), .start(start), .fb_addr(fb_addr), .zb_addr(zb_addr),
        .dx(dx), .z1(z1), .slope(slope), .rem(rem), .err(err), .rgbx(rgbx),
        .zfunc(zfunc), .zwrite_en(zwrite_en), .bus(bus),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    typedef struct { int kind; logic [31:0] addr; int len; int beats; } xfer_t;
    typedef struct { logic [31:0] z; logic [31:0] f; logic p; } pix_t;

    xfer_t       obs_x[$], exp_x[$];
    pix_t        obs_p[$], exp_p[$];
    logic [31:0] zexist [0:1023];
    logic [31:0] fexist [0:1023];
    int          tests = 0, fails = 0;
    int          drain_cnt, exp_drain, clash_cnt, span_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_z(input int i);
        return (i < obs_p.size()) ? obs_p[i].z : 32'hDEAD_BEEF;
    endfunction

    function automatic logic obs_pass(input int i);
        return (i < obs_p.size()) ? obs_p[i].p : 1'bx;
    endfunction

    // Reference model: whole-span expectations from the current configuration.
    task automatic build_expect();
        int z, s, e, e2, off, left, l;
        logic [31:0] zu;
        logic p;
        exp_x.delete(); exp_p.delete(); exp_drain = 0;
        z = $signed(z1); s = $signed(slope); e = int'(err);
        for (int i = 0; i < int'(dx); i++) begin
            zu = z;
            case (zfunc)
                2'd0:    p = (zu <  zexist[i]);
                2'd1:    p = (zu <= zexist[i]);
                2'd2:    p = (zu >  zexist[i]);
                default: p = 1'b1;
            endcase
            exp_p.push_back('{z: (p && zwrite_en) ? zu : zexist[i], f: p ? rgbx : fexist[i], p: p});
            e2 = e + int'(rem);
            if (e2 >= int'(dx)) begin
                z = z + s + ((s < 0) ? -1 : 1);
                e = e2 - int'(dx);
            end else begin
                z = z + s;
                e = e2;
            end
        end
        off = 0; left = int'(dx);
        while (left > 0) begin
            l = (left > BL) ? BL : left;
            if (zfunc != 2'd3) exp_x.push_back('{K_RZ, zb_addr + off, l, l});
            exp_x.push_back('{K_RF, fb_addr + off, l, l});
            if (zwrite_en) exp_x.push_back('{K_WZ, zb_addr + off, l, l});
            else exp_drain += l;
            exp_x.push_back('{K_WF, fb_addr + off, l, l});
            off += l * PB;
            left -= l;
        end
    endtask

    task automatic record_beat(input int k);
        xfer_t t;
        if (obs_x.size() == 0 || obs_x[$].kind != k || obs_x[$].addr != bus.mem_addr ||
            obs_x[$].len != int'(bus.mem_len) || obs_x[$].beats >= obs_x[$].len) begin
            obs_x.push_back('{k, bus.mem_addr, int'(bus.mem_len), 1});
        end else begin
            t = obs_x.pop_back();
            t.beats++;
            obs_x.push_back(t);
        end
    endtask

    // Runs one span with random bus beats, logs transfers/pixels, then compares.
    task automatic run_span(input string tag);
        int pidx = 0;
        obs_x.delete(); obs_p.delete();
        drain_cnt = 0; clash_cnt = 0; span_cycles = 0;
        build_expect();
        @(negedge clk);
        start = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            span_cycles++;
            bus.mem_beat  = ($urandom_range(0, 3) != 0);
            bus.z_fifo_in = (pidx < int'(dx)) ? zexist[pidx] : 32'h0;
            bus.f_fifo_in = (pidx < int'(dx)) ? fexist[pidx] : 32'h0;
            #1;
            if (bus.rd_req && bus.mem_beat) record_beat(bus.z_fifo_push ? K_RZ : K_RF);
            if (bus.wr_req && bus.mem_beat) record_beat(bus.z_out_pop ? K_WZ : K_WF);
            if (bus.rd_req && bus.wr_req) clash_cnt++;
            if (bus.in_pop != bus.out_push) clash_cnt++;
            if (bus.z_out_pop && !bus.wr_req) drain_cnt++;
            if (bus.out_push) obs_p.push_back('{z: bus.z_out, f: bus.f_out, p: bus.pass});
            if (bus.in_pop) pidx++;
        end while (!done && span_cycles < SPAN_LIMIT);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_nxfer"}, obs_x.size(), exp_x.size());
        for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
            check($sformatf("%s_x%0d_kind", tag, i), obs_x[i].kind, exp_x[i].kind);
            check($sformatf("%s_x%0d_addr", tag, i), obs_x[i].addr, exp_x[i].addr);
            check($sformatf("%s_x%0d_len", tag, i), obs_x[i].len, exp_x[i].len);
            check($sformatf("%s_x%0d_beats", tag, i), obs_x[i].beats, exp_x[i].beats);
        end
        check({tag, "_npix"}, obs_p.size(), exp_p.size());
        for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
            check($sformatf("%s_p%0d", tag, i), {obs_p[i].p, obs_p[i].z, obs_p[i].f},
                  {exp_p[i].p, exp_p[i].z, exp_p[i].f});
        end
        check({tag, "_drain"}, drain_cnt, exp_drain);
        check({tag, "_clash"}, clash_cnt, 0);
    endtask

    initial begin
        int seen;
        nreset = 1'b0; start = 1'b0; fb_addr = 32'h0; zb_addr = 32'h0; dx = 16'd0;
        z1 = 32'd0; slope = 32'd0; rem = 16'd0; err = 16'd0; rgbx = 32'd0;
        zfunc = 2'd0; zwrite_en = 1'b1;
        bus.mem_beat = 1'b1; bus.z_fifo_in = 32'h0; bus.f_fifo_in = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", state_dbg, 4'd0);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_req", {bus.rd_req, bus.wr_req, bus.in_pop, bus.out_push, bus.pass}, 5'd0);
        check("rst_addr_len", {bus.mem_addr, bus.mem_len}, 48'd0);
        nreset = 1'b1;

        // Single short burst, all pixels pass.
        fb_addr = 32'h1000_0000; zb_addr = 32'h2000_0000; rgbx = 32'hAABB_CCDD;
        dx = 16'd4; z1 = 32'd100; slope = 32'd10; rem = 16'd0; err = 16'd0;
        zfunc = 2'd0; zwrite_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin zexist[i] = 32'd1000; fexist[i] = $urandom(); end
        run_span("t1");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_z%0d", i), obs_z(i), 32'(100 + 10 * i));
            check($sformatf("t1_pass%0d", i), obs_pass(i), 1'b1);
        end
        check("t1_len", (obs_x.size() > 0) ? obs_x[0].len : -1, 4);

        // Two bursts: full then partial.
        dx = 16'd300; slope = 32'd1;
        run_span("t2");
        check("t2_nx", obs_x.size(), 8);
        check("t2_zaddr2", (obs_x.size() > 4) ? obs_x[4].addr : 32'h0, 32'h2000_0400);
        check("t2_faddr2", (obs_x.size() > 5) ? obs_x[5].addr : 32'h0, 32'h1000_0400);
        check("t2_len2", (obs_x.size() > 4) ? obs_x[4].len : -1, 44);

        // Compare functions on a flat span.
        dx = 16'd3; z1 = 32'd50; slope = 32'd0;
        zexist[0] = 32'd40; zexist[1] = 32'd50; zexist[2] = 32'd60;
        for (int f = 0; f < 3; f++) begin
            zfunc = 2'(f);
            run_span($sformatf("t3f%0d", f));
            check($sformatf("t3_pass_f%0d", f), {obs_pass(0), obs_pass(1), obs_pass(2)},
                  (f == 0) ? 3'b001 : (f == 1) ? 3'b011 : 3'b100);
        end

        // Negative slope with error overflow; ALWAYS skips the z load.
        dx = 16'd3; z1 = 32'd20; slope = 32'hFFFF_FFFE; rem = 16'd1; err = 16'd0; zfunc = 2'd3;
        run_span("t4");
        check("t4_z", {obs_z(0), obs_z(1), obs_z(2)}, {32'd20, 32'd18, 32'd16});

        // z writes suppressed; z output FIFO drained.
        dx = 16'd10; zwrite_en = 1'b0; rem = 16'd3; err = 16'd2;
        run_span("t5");
        check("t5_drain", drain_cnt, 10);

        // Empty span.
        dx = 16'd0; zwrite_en = 1'b1; zfunc = 2'd0;
        run_span("t6");
        check("t6_nx", obs_x.size(), 0);

        // Reset in the middle of the colour load, then a fresh span.
        dx = 16'd20; z1 = 32'd7; slope = 32'd3; rem = 16'd0; err = 16'd0;
        @(negedge clk); start = 1'b1; bus.mem_beat = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int c = 0; c < 200 && seen == 0; c++) begin
            @(negedge clk); #1;
            if (bus.rd_req && bus.f_fifo_push) seen = 1;
        end
        check("t7_reach_ldf", seen, 1);
        nreset = 1'b0;
        @(negedge clk); #1;
        check("t7_rst_rdreq", bus.rd_req, 1'b0);
        check("t7_rst_state", {busy, state_dbg}, 5'd0);
        nreset = 1'b1;
        run_span("t7");

        // Random spans.
        for (int r = 0; r < 6; r++) begin
            dx = 16'($urandom_range(1, 400));
            z1 = $urandom(); slope = (r % 2 == 0) ? $urandom() : 32'($signed($urandom_range(0, 200)) - 100);
            rem = 16'($urandom_range(0, int'(dx) - 1)); err = 16'($urandom_range(0, int'(dx) - 1));
            zfunc = 2'($urandom_range(0, 3)); zwrite_en = 1'($urandom_range(0, 1));
            fb_addr = $urandom() & 32'hFFFF_FFFC; zb_addr = $urandom() & 32'hFFFF_FFFC; rgbx = $urandom();
            for (int i = 0; i < 1024; i++) begin zexist[i] = $urandom(); fexist[i] = $urandom(); end
            run_span($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
